tick_capture: RTL
=================

TICK_CAPTURE -- requirements
Module: tick_capture

Interface
REQ-001 SHALL have parameter N, default 32, counter and capture width in bits.
REQ-002 SHALL have port Clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port Rst, input, 1 bit, reset that is synchronous and active-low.
REQ-004 SHALL have port Pwr_off, input, 1 bit, power-off; when high it forces the reset state synchronously.
REQ-005 SHALL have port En, input, 1 bit, capture enable.
REQ-006 SHALL have port Evt, input, 1 bit, event input, already synchronous to Clk.
REQ-007 SHALL have port Ack, input, 1 bit, consumer acknowledge of the captured value.
REQ-008 SHALL have port Vout, output, N bits, last captured period in Clk cycles.
REQ-009 SHALL have port Valid, output, 1 bit, high while Vout is unacknowledged.
REQ-010 SHALL have port Ovf, output, 1 bit, high when the period held in Vout exceeded the counter range.
REQ-011 SHALL have port Ovr, output, 1 bit, sticky overrun flag: a capture overwrote an unacknowledged value.

Function
REQ-012 SHALL detect rising edges of Evt against a one-cycle registered copy; edge = Evt & ~Evt_q.
REQ-013 SHALL implement states IDLE, ARMED and MEASURE.
REQ-014 SHALL move IDLE->ARMED when En=1, and any state->IDLE when En=0.
REQ-015 SHALL move ARMED->MEASURE on an edge, loading the counter with 1 on the next cycle.
REQ-016 SHALL increment the counter by 1 every MEASURE cycle without an edge.
REQ-017 SHALL, on an edge in MEASURE, register Vout<=counter, Valid<=1, and Ovf<=overflow status, all visible the next cycle; the counter restarts at 1 and the state stays MEASURE.
REQ-018 SHALL make edges exactly P cycles apart give Vout=P, with Valid rising 1 cycle after the second edge.
REQ-019 SHALL clear Valid the cycle after Ack=1 while Valid=1; Ack with Valid=0 SHALL be ignored.
REQ-020 SHALL, on a capture and Ack in the same cycle, let the capture win: Valid stays 1, Vout takes the new value, Ovr is unchanged.
REQ-021 SHALL set Ovr on a capture while Valid=1 and Ack=0; Ovr SHALL clear only with an accepted Ack.
REQ-022 SHALL, when En falls mid-measurement, clear the counter and the edge state, while Vout, Valid, Ovf and Ovr retain their values.
REQ-023 SHALL ignore an edge coincident with En rising; arming takes effect the following cycle.

Reset
REQ-024 SHALL, with Rst=0 or Pwr_off=1 at a clock edge, set state=IDLE, counter=0, Evt_q=0, Vout=0, Valid=0, Ovf=0, Ovr=0.
REQ-025 SHALL give reset priority over all inputs, including a reset mid-measurement or during Valid.

Configuration
REQ-026 SHALL use macro TICK_CAPTURE_SAT_EN to select the counter overflow behaviour.
REQ-027 SHALL, with TICK_CAPTURE_SAT_EN defined, saturate the counter at 2^N-1 and set an internal overflow bit.
REQ-028 SHALL, without TICK_CAPTURE_SAT_EN, wrap the counter from 2^N-1 to 0 and set the internal overflow bit on the wrap.
REQ-029 SHALL clear the internal overflow bit when the counter restarts (capture, En=0, reset).

Structure
REQ-030 SHALL place the state enum (IDLE/ARMED/MEASURE) and the counter load constant (1) in package tick_capture_pkg.
REQ-031 SHALL isolate the counter in sub-module tick_cnt (load-1, increment, clear, wrap/saturate, overflow bit), instantiated once.

Verification
REQ-032 SHALL cover: N=32, En=1, Evt edges at cycles 10 and 35 -> Vout=25, Valid=1 at cycle 36, Ovf=0.
REQ-033 SHALL cover: N=4 with TICK_CAPTURE_SAT_EN, edges 20 cycles apart -> Vout=15, Ovf=1; without the macro -> Vout=4 (20 mod 16), Ovf=1.
REQ-034 SHALL cover: periodic edges every 8 cycles, Ack never asserted -> Vout=8 on each capture, Ovr=1 after the second capture; Ack -> Valid=0, Ovr=0 next cycle.
REQ-035 SHALL cover: Ack asserted in the same cycle as a capture edge -> Valid stays 1, Vout updated, Ovr unchanged.
REQ-036 SHALL cover: En dropped 5 cycles after the first edge, re-raised, edges 12 apart -> Vout=12, with no stale count.
REQ-037 SHALL cover: Rst=0 (and separately Pwr_off=1) during MEASURE with Valid=1 -> all outputs 0 next cycle, state IDLE.

Source files
------------

// File: rtl/tick_capture_pkg.sv
// Shared definitions for the tick_capture period-measurement block:
// controller state encoding and the value the period counter restarts at.
package tick_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    MEASURE = 2'd2
  } state_t;

  // The counter restarts at 1 so that a capture P cycles after the
  // previous edge reads exactly P.
  localparam int unsigned CNT_LOAD = 1;

endpackage

// File: rtl/tick_cnt.sv
// Period counter for tick_capture: clear, load-with-1, increment, and an
// overflow bit that is sticky until the next restart.
// Build option: define TICK_CAPTURE_SAT_EN to saturate at 2^N-1 instead
// of wrapping to 0.
module tick_cnt
  import tick_capture_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         Pwr_off,
  input  logic         clr,
  input  logic         load,
  input  logic         inc,
  output logic [N-1:0] cnt,
  output logic         ovf
);

  // Next count after one increment, MSB flags that the range was exceeded.
  function automatic logic [N:0] cnt_step(input logic [N-1:0] cur);
`ifdef TICK_CAPTURE_SAT_EN
    if (&cur) return {1'b1, cur};
    return {1'b0, cur + N'(1)};
`else
    return {&cur, cur + N'(1)};
`endif
  endfunction

  logic [N:0] step;

  assign step = cnt_step(cnt);

  // Restart, advance or hold the period count and its overflow bit
  always_ff @(posedge Clk) begin
    if (!Rst || Pwr_off || clr) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (load) begin
      cnt <= N'(CNT_LOAD);
      ovf <= 1'b0;
    end else if (inc) begin
      cnt <= step[N-1:0];
      ovf <= ovf | step[N];
    end
  end

endmodule

// File: rtl/tick_capture.sv
// tick_capture: measures the number of Clk cycles between successive
// rising edges of Evt and hands the result to a consumer with a
// Valid/Ack handshake, an overflow flag and a sticky overrun flag.
// Build option: TICK_CAPTURE_SAT_EN (saturating counter, see tick_cnt).
module tick_capture
  import tick_capture_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         Pwr_off,
  input  logic         En,
  input  logic         Evt,
  input  logic         Ack,
  output logic [N-1:0] Vout,
  output logic         Valid,
  output logic         Ovf,
  output logic         Ovr
);

  state_t       state_q;
  state_t       state_d;
  logic         rst_act;
  logic         evt_q;
  logic         evt_edge;
  logic         capture;
  logic         cnt_clr;
  logic         cnt_load;
  logic         cnt_inc;
  logic         cnt_ovf;
  logic [N-1:0] cnt;

  assign rst_act  = !Rst || Pwr_off;
  assign evt_edge = Evt & ~evt_q;

  tick_cnt #(
    .N(N)
  ) u_cnt (
    .Clk     (Clk),
    .Rst     (Rst),
    .Pwr_off (Pwr_off),
    .clr     (cnt_clr),
    .load    (cnt_load),
    .inc     (cnt_inc),
    .cnt     (cnt),
    .ovf     (cnt_ovf)
  );

  // Controller state register
  always_ff @(posedge Clk) begin
    if (rst_act) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state and counter control; dropping En always returns to IDLE
  // and discards the partial count. An edge seen in IDLE only arms.
  always_comb begin
    state_d  = state_q;
    cnt_clr  = 1'b0;
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;
    capture  = 1'b0;
    if (!En) begin
      state_d = IDLE;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = ARMED;
          cnt_clr = 1'b1;
        end
        ARMED: begin
          if (evt_edge) begin
            state_d  = MEASURE;
            cnt_load = 1'b1;
          end
        end
        MEASURE: begin
          if (evt_edge) begin
            capture  = 1'b1;
            cnt_load = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_clr = 1'b1;
        end
      endcase
    end
  end

  // Registered copy of Evt for edge detection; forgotten while disabled
  always_ff @(posedge Clk) begin
    if (rst_act) evt_q <= 1'b0;
    else         evt_q <= Evt & En;
  end

  // Capture register and handshake; a capture beats a simultaneous Ack
  always_ff @(posedge Clk) begin
    if (rst_act) begin
      Vout  <= '0;
      Valid <= 1'b0;
      Ovf   <= 1'b0;
      Ovr   <= 1'b0;
    end else if (capture) begin
      Vout  <= cnt;
      Ovf   <= cnt_ovf;
      Valid <= 1'b1;
      if (Valid && !Ack) Ovr <= 1'b1;
    end else if (Ack && Valid) begin
      Valid <= 1'b0;
      Ovr   <= 1'b0;
    end
  end

endmodule
